// File: rtl/keccak_pkg.sv
// Shared widths and the sponge sequencing state type for the Keccak hash datapath.
package keccak_pkg;

  localparam int WORD_W      = 64;
  localparam int RATE_WORDS  = 9;
  localparam int RATE_BITS   = WORD_W * RATE_WORDS;
  localparam int STATE_BITS  = 1600;
  localparam int DIGEST_BITS = 512;
  localparam int CNT_W       = $clog2(RATE_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } sponge_state_e;

endpackage

// File: rtl/sponge_block_buffer.sv
// Rate-block shift register with word counter and sticky last-block flag.
module sponge_block_buffer
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_i,
  input  logic [WORD_W-1:0]    word_i,
  input  logic                 last_i,
  input  logic                 clr_last_i,
  output logic [RATE_BITS-1:0] blk_o,
  output logic                 full_o,
  output logic                 last_o
);

  logic [RATE_BITS-1:0] blk_q, blk_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_q, last_d;

  // full flags the word that completes the block, so the FSM can leave FILL on that same edge
  assign full_o = shift_i && (cnt_q == CNT_W'(RATE_WORDS - 1));

  always_comb begin
    blk_d  = blk_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (shift_i) begin
      blk_d = {blk_q[RATE_BITS-WORD_W-1:0], word_i};
      cnt_d = full_o ? '0 : cnt_q + CNT_W'(1);
    end
    if (clr_last_i) begin
      last_d = 1'b0;
    end else if (shift_i && last_i) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      blk_q  <= blk_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign blk_o  = blk_q;
  assign last_o = last_q;

endmodule

// File: rtl/sponge_ctrl.sv
// Sponge absorb/squeeze sequencer between the padder and the Keccak permutation core.
//   state | meaning
//   IDLE  | no message yet, accepting first word
//   FILL  | collecting words of a rate block
//   SEND  | block offered to the core, waiting for ack
//   WAIT  | final block absorbed, waiting for permutation result
//   DONE  | digest held; first cycle pulses perm_clear
module sponge_ctrl
  import keccak_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_W-1:0]      in_word,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [RATE_BITS-1:0]   perm_in,
  output logic                   perm_in_ready,
  input  logic                   perm_ack,
  input  logic                   perm_out_ready,
  input  logic [STATE_BITS-1:0]  perm_out,
  output logic                   perm_clear,
  output logic [DIGEST_BITS-1:0] digest,
  output logic                   digest_valid,
  output logic                   busy
);

  sponge_state_e          state_q, state_d;
  logic [DIGEST_BITS-1:0] digest_q, digest_d;
  logic                   digest_valid_q, digest_valid_d;
  logic                   perm_clear_q, perm_clear_d;
  logic                   accept;
  logic                   full;
  logic                   last_flag;
  logic                   clr_last;
  logic                   unused_perm_bits;

  // The first DONE cycle is the clear cycle; the core is being wiped, so hold off input then
  assign in_ready = (state_q == IDLE) || (state_q == FILL) ||
                    ((state_q == DONE) && !perm_clear_q);
  assign accept   = in_valid && in_ready;

  sponge_block_buffer u_buf (
    .clk        (clk),
    .reset      (reset),
    .shift_i    (accept),
    .word_i     (in_word),
    .last_i     (in_last),
    .clr_last_i (clr_last),
    .blk_o      (perm_in),
    .full_o     (full),
    .last_o     (last_flag)
  );

  always_comb begin
    state_d        = state_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    perm_clear_d   = 1'b0;
    clr_last       = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (accept) state_d = full ? SEND : FILL;
      end
      SEND: begin
        if (perm_ack) begin
          clr_last = 1'b1;
          state_d  = last_flag ? WAIT : FILL;
        end
      end
      WAIT: begin
        if (perm_out_ready) begin
          digest_d       = perm_out[STATE_BITS-1 -: DIGEST_BITS];
          digest_valid_d = 1'b1;
          perm_clear_d   = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          digest_valid_d = 1'b0;
          state_d        = full ? SEND : FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      perm_clear_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      perm_clear_q   <= perm_clear_d;
    end
  end

  assign perm_in_ready    = (state_q == SEND);
  assign perm_clear       = perm_clear_q;
  assign digest           = digest_q;
  assign digest_valid     = digest_valid_q;
  assign busy             = (state_q != IDLE) && (state_q != DONE);
  assign unused_perm_bits = ^perm_out[STATE_BITS-DIGEST_BITS-1:0];

endmodule
